serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only when busy=0.
REQ-005 Port: a  input  WIDTH  operand A; captured at the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; captured at the accepting edge.
REQ-007 Port: ci  input  1  carry-in; captured at the accepting edge.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; s and co are valid.
REQ-010 Port: s  output  WIDTH  sum result.
REQ-011 Port: co  output  1  carry-out of the MSB.

Function
REQ-012 The block SHALL compute {co,s} = a + b + ci bit-serially, LSB first, using one 1-bit full-adder slice: S = x^y^c, C = (x&y)|((x^y)&c).
REQ-013 The block SHALL use three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at edge E SHALL latch a, b and ci into internal registers, clear the bit counter, and enter RUN.
REQ-015 In IDLE or DONE, start=0 SHALL leave the machine in IDLE.
REQ-016 RUN SHALL process exactly one bit per cycle, index 0..WIDTH-1.
REQ-017 Bit results SHALL be shifted into the result register MSB-first so that s[i] holds bit i on completion.
REQ-018 The carry register SHALL be updated every RUN cycle.
REQ-019 Completion timing: after the bit WIDTH-1 edge (E+WIDTH), the block SHALL enter DONE with s and co holding the final values.
REQ-020 done SHALL be 1 only in DONE, which lasts exactly one cycle.
REQ-021 busy SHALL be 1 only in RUN, i.e. from edge E through edge E+WIDTH.
REQ-022 start SHALL be ignored while busy=1; operands SHALL NOT be re-latched.
REQ-023 s and co SHALL hold their last completed values until the next accepted start.
REQ-024 During RUN, s SHALL show partial shift contents, which are don't-care for consumers.
REQ-025 A start in DONE SHALL be accepted back-to-back with no idle cycle.
REQ-026 Arithmetic SHALL be unsigned modulo 2^WIDTH; overflow appears only in co.
REQ-027 Input changes on a, b or ci after edge E SHALL NOT affect the result.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE with busy=0, done=0, s=0, co=0, and the carry register and bit counter cleared.
REQ-029 rst SHALL take priority over start and over RUN; an operation in progress SHALL be aborted with no done pulse.

Configuration
REQ-030 Macro SERIAL_SUB_EN SHALL control subtraction support as follows.
REQ-031 With SERIAL_SUB_EN defined, the block SHALL add input port sub (1 bit), captured at the accepting edge.
REQ-032 With SERIAL_SUB_EN defined and sub=1, the block SHALL compute a + ~b + 1, ignoring ci; co=1 means no borrow.
REQ-033 With SERIAL_SUB_EN defined and sub=0, behaviour SHALL be identical to addition.
REQ-034 Without SERIAL_SUB_EN, port sub SHALL NOT exist and the block SHALL be addition only.

Verification (WIDTH=8)
REQ-035 a=8'h0F, b=8'h01, ci=0, start pulse at E: expect busy high for E..E+8, then done=1 for one cycle with s=8'h10, co=0.
REQ-036 a=8'hFF, b=8'h01, ci=0: expect s=8'h00, co=1. a=8'hFF, b=8'hFF, ci=1: expect s=8'hFF, co=1.
REQ-037 start held high with new operands during RUN: expect the original result, and no new operation until DONE.
REQ-038 rst asserted at E+4 mid-RUN: expect next cycle busy=0, done=0, s=0, co=0, and no done pulse afterward.
REQ-039 start asserted in the DONE cycle with a=8'h03, b=8'h04: expect immediate RUN, then s=8'h07 eight cycles later.
REQ-040 With SERIAL_SUB_EN, sub=1, a=8'h05, b=8'h07: expect s=8'hFE, co=0; with a=8'h07, b=8'h05: expect s=8'h02, co=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice, LSB first, IDLE/RUN/DONE control.
// Ports: clk, rst (sync, active-high), start, a, b, ci, [sub], busy, done, s, co.
// Optional macro SERIAL_SUB_EN adds port sub: sub=1 computes a + ~b + 1.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_co;

  logic             w_accept;
  logic             w_last;
  logic             w_x;
  logic             w_y;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

`ifdef SERIAL_SUB_EN
  // Subtract as a + ~b + 1; ci is ignored in that mode.
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : ci;
`else
  assign w_b_in = b;
  assign w_c_in = ci;
`endif

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  assign w_x    = r_a[0];
  assign w_y    = r_b[0];
  assign w_sum  = w_x ^ w_y ^ r_c;
  assign w_cout = (w_x & w_y) | ((w_x ^ w_y) & r_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = start ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = start ? ST_RUN : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
      r_co  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= w_b_in;
      r_c   <= w_c_in;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_cout;
      // Enter at MSB so bit i lands in s[i] after WIDTH shifts.
      r_s   <= {w_sum, r_s[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
      // co only changes on the final bit so it holds between operations.
      if (w_last) r_co <= w_cout;
    end
  end

  assign s  = r_s;
  assign co = r_co;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against an
// arithmetic reference ({co,s} = a + b + ci, or a + ~b + 1 when subtracting).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] last_s;
  logic         last_co;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a  = W'($urandom);
    b  = W'($urandom);
    ci = 1'($urandom);
`ifdef SERIAL_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // Call just after an edge with the block in IDLE or DONE.
  // Returns in the DONE cycle with start low.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tci, input logic tsub, input bit hold);
    logic [W:0] e;
    if (tsub) e = {1'b0, ta} + {1'b0, ~tb_v} + {{W{1'b0}}, 1'b1};
    else      e = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tci};
    a     = ta;
    b     = tb_v;
    ci    = tci;
`ifdef SERIAL_SUB_EN
    sub   = tsub;
`endif
    start = 1'b1;
    tick();
    chk("busy_E", 64'(busy), 64'd1);
    chk("done_E", 64'(done), 64'd0);
    start = hold;
    scramble();
    for (int k = 1; k < W; k++) begin
      tick();
      chk("busy_run", 64'(busy), 64'd1);
      chk("done_run", 64'(done), 64'd0);
      scramble();
    end
    tick();
    start = 1'b0;
    chk("busy_done", 64'(busy), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("sum", 64'(s), 64'(e[W-1:0]));
    chk("carry", 64'(co), 64'(e[W]));
    last_s  = e[W-1:0];
    last_co = e[W];
  endtask

  task automatic idle_check();
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("hold_s", 64'(s), 64'(last_s));
    chk("hold_co", 64'(co), 64'(last_co));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic tsub;
    int   gap;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    rst = 1'b0;
    last_s  = '0;
    last_co = 1'b0;
    idle_check();

    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    idle_check();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    idle_check();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle_check();

    // start held high with changing operands throughout RUN
    do_op(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1);
    idle_check();

    // back-to-back start in the DONE cycle
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    do_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    idle_check();

    // reset sampled at E+4 aborts the run
    a     = 8'hAA;
    b     = 8'h77;
    ci    = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_s", 64'(s), 64'd0);
    chk("abort_co", 64'(co), 64'd0);
    last_s  = '0;
    last_co = 1'b0;
    repeat (W + 2) idle_check();

`ifdef SERIAL_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
    idle_check();
    do_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
    idle_check();
`endif

    repeat (40) begin
      tsub = 1'b0;
`ifdef SERIAL_SUB_EN
      tsub = 1'($urandom);
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom), tsub,
            bit'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
